// File: rtl/uart_tx.sv
// uart_tx: UART transmitter that sends one byte per valid/ready handshake.
// Frame format is start bit, 8 data bits LSB first, optional parity bit,
// and one stop bit. Each line bit lasts CLOCK_FREQ/BAUD_RATE clocks.
// Optional feature: define UART_TX_BUFFER_EN to add a one-byte holding
// register, so a byte can be accepted mid-frame and frames run gapless.
module uart_tx #(
  parameter int unsigned CLOCK_FREQ = 50_000_000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter logic [1:0]  EN_PARITY  = 2'b00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_data,
  input  logic       i_data_valid,
  output logic       o_ready,
  output logic       o_uart_tx,
  output logic       o_busy,
  output logic       o_tx_done
);

  localparam int unsigned MCNT_BAUD = CLOCK_FREQ / BAUD_RATE - 1;
  localparam int unsigned CNT_W     = (MCNT_BAUD > 0) ? $clog2(MCNT_BAUD + 1) : 1;
  localparam logic [CNT_W-1:0] MCNT = CNT_W'(MCNT_BAUD);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_baud_cnt;
  logic [2:0]       r_bit_id;
  logic [2:0]       w_bit_id_next;
  logic [7:0]       r_shift;
  logic             r_tx;
  logic             w_tx_next;
  logic             w_bit_end;
  logic             w_hs;
  logic             w_load_in;
  logic             w_parity;

`ifdef UART_TX_BUFFER_EN
  logic [7:0] r_hold;
  logic       r_hold_full;
  logic       w_load_hold;
  logic       w_hold_wr;

  assign o_ready   = ~r_hold_full;
  // A handshake not consumed directly by the shifter goes to the holding register.
  assign w_hold_wr = w_hs & ~w_load_in;
`else
  assign o_ready   = (r_state == IDLE);
`endif

  assign w_hs      = i_data_valid & o_ready;
  assign w_bit_end = (r_baud_cnt == MCNT);
  assign o_busy    = (r_state != IDLE);
  assign o_tx_done = (r_state == STOP) && w_bit_end;
  assign o_uart_tx = r_tx;

  // Parity bit for the byte currently in the shift register.
  always_comb begin
    w_parity = 1'b1;
    case (EN_PARITY)
      2'b11:   w_parity = ~^r_shift;
      2'b01:   w_parity = ^r_shift;
      default: w_parity = 1'b1;
    endcase
  end

  // Next-state decode and shift-register load requests.
  always_comb begin
    w_next_state = r_state;
    w_load_in    = 1'b0;
`ifdef UART_TX_BUFFER_EN
    w_load_hold  = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (w_hs) begin
          w_next_state = START;
          w_load_in    = 1'b1;
        end
      end
      START: begin
        if (w_bit_end) w_next_state = DATA;
      end
      DATA: begin
        if (w_bit_end && (r_bit_id == 3'd7)) w_next_state = (|EN_PARITY) ? PARITY : STOP;
      end
      PARITY: begin
        if (w_bit_end) w_next_state = STOP;
      end
      STOP: begin
        if (w_bit_end) begin
`ifdef UART_TX_BUFFER_EN
          if (r_hold_full) begin
            w_next_state = START;
            w_load_hold  = 1'b1;
          end else if (w_hs) begin
            w_next_state = START;
            w_load_in    = 1'b1;
          end else begin
            w_next_state = IDLE;
          end
`else
          w_next_state = IDLE;
`endif
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Data bit index for the next cycle; wraps to 0 as DATA is left.
  always_comb begin
    w_bit_id_next = '0;
    if (r_state == DATA) w_bit_id_next = w_bit_end ? (r_bit_id + 3'd1) : r_bit_id;
  end

  // Line level is computed from the next state so the registered line
  // changes on the same edge as the state.
  always_comb begin
    w_tx_next = 1'b1;
    case (w_next_state)
      START:   w_tx_next = 1'b0;
      DATA:    w_tx_next = r_shift[w_bit_id_next];
      PARITY:  w_tx_next = w_parity;
      default: w_tx_next = 1'b1;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Baud counter, bit index and registered line output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_baud_cnt <= '0;
      r_bit_id   <= '0;
      r_tx       <= 1'b1;
    end else begin
      if ((r_state == IDLE) || w_bit_end) r_baud_cnt <= '0;
      else                                r_baud_cnt <= r_baud_cnt + 1'b1;
      r_bit_id <= w_bit_id_next;
      r_tx     <= w_tx_next;
    end
  end

  // Shift register load, from the input or from the holding register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= '0;
    end else if (w_load_in) begin
      r_shift <= i_data;
`ifdef UART_TX_BUFFER_EN
    end else if (w_load_hold) begin
      r_shift <= r_hold;
`endif
    end
  end

`ifdef UART_TX_BUFFER_EN
  // Holding register fill and drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else if (w_hold_wr) begin
      r_hold      <= i_data;
      r_hold_full <= 1'b1;
    end else if (w_load_hold) begin
      r_hold_full <= 1'b0;
    end
  end
`endif

endmodule

// File: doc/uart_tx.md
# uart_tx

Asynchronous serial transmitter: accepts one byte per valid/ready handshake and drives it LSB-first on a UART line with a start bit, optional parity bit and one stop bit. Its frame format matches the team's `uart_rx` block, so the two form a loopback pair. It sits between on-chip byte producers and the TX pin.

## Interface
- `CLOCK_FREQ`, default 50_000_000: input clock frequency in Hz.
- `BAUD_RATE`, default 9600: line bit rate.
- `EN_PARITY`, default 2'b00: parity mode.
  - 00: no parity bit.
  - 11: odd parity.
  - 01: even parity.
  - 10: parity bit always 1 (mark).
- `clk`  input  1  single clock; all logic on its rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `i_data`  input  8  byte to send; sampled only on a handshake.
- `i_data_valid`  input  1  producer has a byte on `i_data`.
- `o_ready`  output  1  block can accept a byte this cycle.
- `o_uart_tx`  output  1  serial line; idles high.
- `o_busy`  output  1  a frame is on the line (any state other than IDLE).
- `o_tx_done`  output  1  one-cycle pulse at the end of each stop bit.

## Operation
- `MCNT_BAUD = CLOCK_FREQ/BAUD_RATE - 1`. Every line bit lasts exactly MCNT_BAUD+1 clocks.
  - Baud counter width is `$clog2(MCNT_BAUD+1)`.
  - The counter runs 0..MCNT_BAUD and clears at each bit boundary.
- Handshake: a byte is accepted on any rising edge where `i_data_valid && o_ready`.
  - When `o_ready` = 0, `i_data_valid` is ignored and nothing is captured; the producer holds the byte.
  - `i_data` may change freely after acceptance.
- FSM states are IDLE, START, DATA, PARITY, STOP.
  - IDLE: line 1. On a handshake, load the shift register and go to START.
  - START: line 0 for one bit time, then DATA with `bit_id`=0.
  - DATA: line = `shift[bit_id]`, one bit time per bit, bits 0..7. After bit 7, go to PARITY if `|EN_PARITY`, else STOP.
  - PARITY: line carries the parity bit for one bit time, then STOP.
    - Odd parity (11): `~^data`.
    - Even parity (01): `^data`.
    - Mode 10: 1.
  - STOP: line 1 for one bit time. At its last cycle pulse `o_tx_done` and go to IDLE.
  - Any illegal state: go to IDLE.
- Frame length is 10 bit times, or 11 with parity.
- `o_ready` (without the buffer) = (state == IDLE), decoded combinationally from the registered state.
- `o_uart_tx` is driven from a register, so the line is glitch-free.
- Reset values:
  - `o_uart_tx` = 1, `o_ready` = 1, `o_busy` = 0, `o_tx_done` = 0.
  - State = IDLE; counters, shift register and holding register cleared.
- Reset asserted mid-frame: the line returns to 1 immediately (asynchronously) and the frame is abandoned. Any buffered byte is discarded.

## Timing
- Handshake at edge N drives `o_uart_tx` to 0 from edge N+1. The start bit spans edges N+1..N+1+MCNT_BAUD.
- `o_tx_done` is high during the final clock of the stop bit. The state is IDLE on the following edge.
- Without the buffer, back-to-back frames have one extra idle-high clock between the stop bit and the next start bit. `o_ready` is high only in IDLE.
- `o_busy` is high from the edge after the handshake until the edge after `o_tx_done`.

## Configuration
- Macro `UART_TX_BUFFER_EN`.
- Defined: adds a one-byte holding register.
  - `o_ready` = holding register empty. A byte can therefore be accepted while a frame is being shifted.
  - At the end of STOP, if the holding register is full, its byte moves to the shift register and the FSM goes directly to START. There is no idle cycle, so frames are gapless.
  - Handshake in IDLE with the holding register empty: the byte goes straight to the shift register.
  - Handshake on the same edge as the end of STOP with the holding register empty: the byte is loaded directly and the FSM goes to START.
- Undefined: no holding register; behaviour is exactly as described in Operation.

## Test plan
Bench uses `CLOCK_FREQ`=160, `BAUD_RATE`=10, so MCNT_BAUD=15 and each bit is 16 clocks.
- Reset, then idle 100 clocks -> `o_uart_tx`=1, `o_ready`=1, `o_busy`=0 throughout.
- `EN_PARITY`=00, send 0x55 -> line reads 0, 1,0,1,0,1,0,1,0, 1, each bit 16 clocks. `o_tx_done` pulses once, 160 clocks after the first start-bit clock minus 1.
- `EN_PARITY`=11, send 0x00, then 0x01 -> parity bits 1 and 0 respectively.
- `EN_PARITY`=01, send 0x03 -> parity bit 0. Loop back through `uart_rx` with the same parameters and `o_uart_data`=0x03 with `o_data_valid`=1.
- Hold `i_data_valid`=1 and change `i_data` mid-frame -> the new value is not captured until `o_ready` is high again.
  - Without `UART_TX_BUFFER_EN`: a one-clock idle gap between frames.
  - With it: zero gap; a second byte is accepted during the first frame and a third is stalled until the holding register empties.
- Assert `rst` during DATA bit 3 -> `o_uart_tx`=1 in the same cycle. After release the next handshake produces a clean full frame.
